// File: rtl/stap_visa_reg_bank.sv
// Bank of NUM_REGS VISA override registers behind one TAP data register.
// The target index is latched at Capture-DR; each write raises a one-cycle update pulse.
module stap_visa_reg_bank #(
    parameter int unsigned NUM_REGS = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUE = '0,
    parameter bit TLR_CLEAR = 1'b1,
    localparam int unsigned SEL_WIDTH = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                           ftap_tck,
    input  logic                           powergoodrst,
    input  logic                           stap_fsm_tlrs,
    input  logic                           stap_fsm_capture_dr,
    input  logic                           stap_fsm_shift_dr,
    input  logic                           stap_fsm_update_dr,
    input  logic                           selected_visa_reg,
    input  logic [SEL_WIDTH-1:0]           visa_reg_sel,
    input  logic                           ftap_tdi,
    output logic                           visa_tdo,
    output logic [NUM_REGS*DATA_WIDTH-1:0] visa_reg_parallel_out,
    output logic [NUM_REGS-1:0]            visa_reg_update_pulse,
    output logic                           visa_reg_sel_err
);

    logic [DATA_WIDTH-1:0]          r_shift;
    logic [NUM_REGS*DATA_WIDTH-1:0] r_data;
    logic [SEL_WIDTH-1:0]           r_latched_sel;
    logic                           r_sel_valid;
    logic [NUM_REGS-1:0]            r_pulse;
    logic                           r_sel_err;

    logic                  w_sel_in_range;
    logic [DATA_WIDTH-1:0] w_cap_data;
    logic [DATA_WIDTH-1:0] w_shift_next;
    logic [NUM_REGS-1:0]   w_wr_hit;

    always_comb begin
        // A single-register bank ignores the index entirely
        w_sel_in_range = (NUM_REGS == 1) || (32'(visa_reg_sel) < NUM_REGS);
        w_cap_data = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if ((NUM_REGS == 1) || (32'(visa_reg_sel) == i))
                w_cap_data = r_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        w_shift_next = '0;
        w_shift_next[DATA_WIDTH-1] = ftap_tdi;
        for (int unsigned i = 0; i + 1 < DATA_WIDTH; i++)
            w_shift_next[i] = r_shift[i+1];
        w_wr_hit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            w_wr_hit[i] = selected_visa_reg && stap_fsm_update_dr && r_sel_valid &&
                          ((NUM_REGS == 1) || (32'(r_latched_sel) == i));
        end
    end

    always_ff @(posedge ftap_tck) begin
        if (powergoodrst) begin
            r_data        <= RESET_VALUE;
            r_shift       <= '0;
            r_latched_sel <= '0;
            r_sel_valid   <= 1'b0;
            r_pulse       <= '0;
            r_sel_err     <= 1'b0;
        end else if (stap_fsm_tlrs) begin
            r_shift     <= '0;
            r_sel_valid <= 1'b0;
            r_pulse     <= '0;
            if (TLR_CLEAR)
                r_data <= RESET_VALUE;
        end else begin
            // Update uses the pre-edge shift value, independent of capture/shift
            r_pulse <= w_wr_hit;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (w_wr_hit[i])
                    r_data[i*DATA_WIDTH +: DATA_WIDTH] <= r_shift;
            end
            if (selected_visa_reg) begin
                if (stap_fsm_capture_dr) begin
                    r_latched_sel <= visa_reg_sel;
                    r_sel_valid   <= w_sel_in_range;
                    r_shift       <= w_sel_in_range ? w_cap_data : '0;
                    if (!w_sel_in_range)
                        r_sel_err <= 1'b1;
                end else if (stap_fsm_shift_dr) begin
                    r_shift <= w_shift_next;
                end
            end
        end
    end

    assign visa_tdo              = r_shift[0];
    assign visa_reg_parallel_out = r_data;
    assign visa_reg_update_pulse = r_pulse;
    assign visa_reg_sel_err      = r_sel_err;

endmodule

// File: tb/tb_stap_visa_reg_bank.sv
// Scoreboard bench: two bank configurations share one stimulus stream and are
// checked against a transaction-level register model.
module tb_stap_visa_reg_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, tlrs, cap, shf, upd, sel_en, tdi;
    logic [1:0] vsel;
    logic       tdo_a, tdo_b, err_a, err_b;
    logic [31:0] pout_a;
    logic [23:0] pout_b;
    logic [3:0]  pulse_a;
    logic [2:0]  pulse_b;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  p;
        logic [31:0] v;
    } pexp_t;

    logic  tdoq_a[$];
    logic  tdoq_b[$];
    pexp_t pq_a[$];
    pexp_t pq_b[$];

    logic [7:0]  m[2][4];
    logic [31:0] rv[2];
    int          nregs[2];
    bit          tclr[2];
    bit          serr[2];
    bit          started = 1'b0;

    stap_visa_reg_bank #(.NUM_REGS(4), .DATA_WIDTH(8),
                         .RESET_VALUE(32'h44332211), .TLR_CLEAR(1'b1)) u_dut_a (
        .ftap_tck(clk), .powergoodrst(rst), .stap_fsm_tlrs(tlrs),
        .stap_fsm_capture_dr(cap), .stap_fsm_shift_dr(shf), .stap_fsm_update_dr(upd),
        .selected_visa_reg(sel_en), .visa_reg_sel(vsel), .ftap_tdi(tdi),
        .visa_tdo(tdo_a), .visa_reg_parallel_out(pout_a),
        .visa_reg_update_pulse(pulse_a), .visa_reg_sel_err(err_a));

    stap_visa_reg_bank #(.NUM_REGS(3), .DATA_WIDTH(8),
                         .RESET_VALUE(24'h332211), .TLR_CLEAR(1'b0)) u_dut_b (
        .ftap_tck(clk), .powergoodrst(rst), .stap_fsm_tlrs(tlrs),
        .stap_fsm_capture_dr(cap), .stap_fsm_shift_dr(shf), .stap_fsm_update_dr(upd),
        .selected_visa_reg(sel_en), .visa_reg_sel(vsel), .ftap_tdi(tdi),
        .visa_tdo(tdo_b), .visa_reg_parallel_out(pout_b),
        .visa_reg_update_pulse(pulse_b), .visa_reg_sel_err(err_b));

    function automatic logic [31:0] flat(int d);
        logic [31:0] f = '0;
        for (int i = 0; i < 4; i++)
            if (i < nregs[d]) f[i*8 +: 8] = m[d][i];
        return f;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic mon_tdo(int d, logic tdo);
        logic e;
        bit   have;
        if (d == 0) begin
            have = tdoq_a.size() > 0;
            if (have) e = tdoq_a.pop_front();
        end else begin
            have = tdoq_b.size() > 0;
            if (have) e = tdoq_b.pop_front();
        end
        if (!have) begin
            checks++; errors++;
            $display("FAIL tdo%0d unexpected shift cycle got %b", d, tdo);
        end else begin
            chk($sformatf("tdo%0d", d), 32'(tdo), 32'(e));
        end
    endtask

    task automatic mon_pulse(int d, logic [3:0] p, logic [31:0] v);
        pexp_t e;
        bit    have;
        if (d == 0) begin
            have = pq_a.size() > 0;
            if (have) e = pq_a.pop_front();
        end else begin
            have = pq_b.size() > 0;
            if (have) e = pq_b.pop_front();
        end
        if (!have) begin
            checks++; errors++;
            $display("FAIL pulse%0d unexpected got %b expected none", d, p);
        end else begin
            chk($sformatf("pulse%0d", d), 32'(p), 32'(e.p));
            chk($sformatf("pulse_data%0d", d), v, e.v);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            if (shf && sel_en) begin
                mon_tdo(0, tdo_a);
                mon_tdo(1, tdo_b);
            end
            if (pulse_a !== 4'b0) mon_pulse(0, pulse_a, pout_a);
            if (pulse_b !== 3'b0) mon_pulse(1, {1'b0, pulse_b}, {8'b0, pout_b});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset_regs(int d);
        for (int i = 0; i < 4; i++) m[d][i] = rv[d][i*8 +: 8];
    endtask

    task automatic check_state(string tag);
        chk({tag, "_pout_a"}, pout_a, flat(0));
        chk({tag, "_pout_b"}, {8'b0, pout_b}, flat(1));
        chk({tag, "_err_a"}, 32'(err_a), 32'(serr[0]));
        chk({tag, "_err_b"}, 32'(err_b), 32'(serr[1]));
        chk({tag, "_pend_a"}, 32'(pq_a.size()), 32'd0);
        chk({tag, "_pend_b"}, 32'(pq_b.size()), 32'd0);
    endtask

    task automatic check_reset_outputs(string tag);
        check_state(tag);
        chk({tag, "_pulse_a"}, 32'(pulse_a), 32'd0);
        chk({tag, "_pulse_b"}, 32'(pulse_b), 32'd0);
        chk({tag, "_tdo_a"}, 32'(tdo_a), 32'd0);
        chk({tag, "_tdo_b"}, 32'(tdo_b), 32'd0);
    endtask

    task automatic do_reset();
        cap = 0; shf = 0; upd = 0; tlrs = 0;
        rst = 1; cyc(); cyc(); rst = 0;
        for (int d = 0; d < 2; d++) begin
            model_reset_regs(d);
            serr[d] = 1'b0;
        end
        cyc();
    endtask

    task automatic do_tlr();
        tlrs = 1; cyc(); tlrs = 0;
        for (int d = 0; d < 2; d++)
            if (tclr[d]) model_reset_regs(d);
        cyc();
        check_state("tlr");
    endtask

    // One full Capture/Shift(8)/Update scan; chg moves visa_reg_sel mid-shift.
    task automatic scan(input logic [1:0] sel, input logic [7:0] data,
                        input bit en, input bit chg, input logic [1:0] later_sel);
        bit valid[2];
        sel_en = en; vsel = sel; cap = 1;
        cyc();
        cap = 0;
        for (int d = 0; d < 2; d++) begin
            valid[d] = int'(sel) < nregs[d];
            if (en && !valid[d]) serr[d] = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            shf = 1; tdi = data[k];
            if (chg) vsel = later_sel;
            if (en) begin
                tdoq_a.push_back(valid[0] ? m[0][sel][k] : 1'b0);
                tdoq_b.push_back(valid[1] ? m[1][sel][k] : 1'b0);
            end
            cyc();
        end
        shf = 0; upd = 1;
        for (int d = 0; d < 2; d++) begin
            if (en && valid[d]) begin
                m[d][sel] = data;
                if (d == 0) pq_a.push_back('{p: 4'(1 << sel), v: flat(0)});
                else        pq_b.push_back('{p: 4'(1 << sel), v: flat(1)});
            end
        end
        cyc();
        upd = 0;
        cyc(); cyc();
        check_state("scan");
    endtask

    task automatic abort_scan();
        sel_en = 1; vsel = 2'd1; cap = 1;
        cyc();
        cap = 0;
        for (int k = 0; k < 4; k++) begin
            shf = 1; tdi = 1'($urandom);
            tdoq_a.push_back(m[0][1][k]);
            tdoq_b.push_back(m[1][1][k]);
            cyc();
        end
        shf = 0;
        do_reset();
        check_reset_outputs("abort");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; tlrs = 0; cap = 0; shf = 0; upd = 0; sel_en = 0; tdi = 0; vsel = 0;
        nregs[0] = 4; nregs[1] = 3;
        tclr[0]  = 1; tclr[1]  = 0;
        rv[0] = 32'h44332211; rv[1] = 32'h00332211;
        do_reset();
        started = 1'b1;
        check_reset_outputs("reset");

        scan(2'd2, 8'hA5, 1, 0, 2'd0);
        scan(2'd2, 8'h5A, 1, 0, 2'd0);
        scan(2'd1, 8'h3C, 1, 1, 2'd3);
        scan(2'd3, 8'hFF, 1, 0, 2'd0);
        do_tlr();

        do_reset();
        scan(2'd0, 8'h77, 1, 0, 2'd0);
        do_tlr();

        scan(2'd1, 8'h99, 0, 0, 2'd0);
        abort_scan();

        for (int n = 0; n < 40; n++) begin
            scan(2'($urandom_range(0, 3)), 8'($urandom), $urandom_range(0, 7) != 0,
                 1'($urandom), 2'($urandom));
            if ($urandom_range(0, 9) == 0) do_tlr();
        end

        cyc(); cyc();
        chk("tdoq_a_empty", 32'(tdoq_a.size()), 32'd0);
        chk("tdoq_b_empty", 32'(tdoq_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stap_visa_reg_bank.md
Name: stap_visa_reg_bank

Overview:
- Parametrised successor to the single VISA override data register.
- Holds NUM_REGS independent VISA override registers, each DATA_WIDTH bits, behind one selectable TAP data register.
- Owns its own capture/shift path, and latches the target register index at Capture-DR.
- Emits a one-cycle update pulse per register and supports an optional Test-Logic-Reset clear.
- Sits between the sTAP FSM/IR decode and the VISA mux override controls.

Parameters:
- NUM_REGS, 4, number of override registers (1..16).
- DATA_WIDTH, 8, width of each register and of the shift path (>=1).
- RESET_VALUE, 0, concatenated reset values, NUM_REGS*DATA_WIDTH bits; register i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- TLR_CLEAR, 1, when 1, stap_fsm_tlrs restores RESET_VALUE; when 0, registers survive TLR.
- SEL_WIDTH, derived localparam: max(1, clog2(NUM_REGS)).

Ports:
- ftap_tck  in  1  TAP clock; all state updates on posedge.
- powergoodrst  in  1  reset, synchronous, active-high.
- stap_fsm_tlrs  in  1  FSM in Test-Logic-Reset.
- stap_fsm_capture_dr  in  1  FSM in Capture-DR.
- stap_fsm_shift_dr  in  1  FSM in Shift-DR.
- stap_fsm_update_dr  in  1  FSM in Update-DR.
- selected_visa_reg  in  1  IR decodes to this bank.
- visa_reg_sel  in  SEL_WIDTH  target register index; sampled only at capture.
- ftap_tdi  in  1  serial data in.
- visa_tdo  out  1  serial data out, equal to shift_reg[0].
- visa_reg_parallel_out  out  NUM_REGS*DATA_WIDTH  register contents.
- visa_reg_update_pulse  out  NUM_REGS  one-hot, 1-cycle pulse after a register is written.
- visa_reg_sel_err  out  1  sticky flag: a capture hit an out-of-range index.

Behaviour:
- Reset (powergoodrst=1, sampled on posedge ftap_tck):
  - parallel_out = RESET_VALUE.
  - shift_reg = 0, latched_sel = 0, sel_valid = 0, update_pulse = 0, sel_err = 0.
  - visa_tdo therefore reads 0.
- Priority, highest first: powergoodrst > stap_fsm_tlrs > FSM state actions.
- TLR (stap_fsm_tlrs=1):
  - shift_reg = 0, sel_valid = 0, update_pulse = 0.
  - If TLR_CLEAR=1, parallel_out = RESET_VALUE.
  - sel_err is retained; only powergoodrst clears it.
- All FSM actions below are gated by selected_visa_reg=1. When it is 0, shift_reg, latched_sel and the registers hold.
- Capture (capture_dr=1):
  - latched_sel = visa_reg_sel.
  - If visa_reg_sel < NUM_REGS: sel_valid = 1 and shift_reg = register[visa_reg_sel].
  - Otherwise: sel_valid = 0, shift_reg = 0, sel_err = 1.
- Shift (shift_dr=1): shift_reg = {ftap_tdi, shift_reg[DATA_WIDTH-1:1]}, LSB first out.
  - visa_tdo is combinational from shift_reg[0], so it is valid for the whole Shift-DR cycle.
- Update (update_dr=1 and sel_valid=1):
  - register[latched_sel] = shift_reg on the same edge.
  - update_pulse[latched_sel] = 1 for exactly the next cycle; all other bits 0.
  - With sel_valid=0, Update writes nothing and raises no pulse.
- update_pulse defaults to 0 every cycle it is not set.
- Changes on visa_reg_sel after Capture-DR have no effect until the next capture.
- If more than one FSM input is asserted (illegal), shift_reg priority is capture > shift. Update acts independently, using shift_reg's pre-edge value.
- Latency:
  - Capture to tdo valid: 1 cycle.
  - Update to parallel_out change: 1 cycle.
  - Pulse aligns with the new parallel_out value.
- NUM_REGS=1: visa_reg_sel is ignored (index 0 is always valid), so sel_err never sets.
- Reset asserted mid-shift aborts the scan; no register is written.

Test Plan:
- Reset value: NUM_REGS=4, DATA_WIDTH=8, RESET_VALUE=0x44332211; assert reset for 2 cycles -> parallel_out=0x44332211, update_pulse=0, visa_tdo=0, sel_err=0.
- Write and read back: sel=2; capture, shift 8 bits of 0xA5 LSB first, update.
  - Required: register[2]=0xA5, the other three unchanged, update_pulse=4'b0100 for exactly 1 cycle.
  - Then capture/shift 8 with sel=2 -> tdo bits form 0xA5.
- Select latched at capture: capture with sel=1, change sel to 3 during shift of 0x3C, update -> register[1]=0x3C, register[3] unchanged, pulse=4'b0010.
- Out-of-range index: NUM_REGS=3, sel=3; capture/shift 0xFF/update -> no register changes, no pulse, sel_err=1. sel_err stays 1 after a subsequent TLR.
- TLR clear:
  - TLR_CLEAR=1: write 0x77 to reg 0, assert stap_fsm_tlrs 1 cycle -> reg 0 returns to 0x11.
  - TLR_CLEAR=0: same sequence -> reg 0 stays 0x77.
- Deselected and abort:
  - selected_visa_reg=0 during capture/shift/update -> no register change, no pulse.
  - Reset asserted after 4 of 8 shift bits -> all outputs return to reset values.
